mimo_split: RTL



---
 rtl/mimo_pkg.sv | 17 +
 rtl/mimo_split_if.sv | 32 +++
 rtl/mimo_insert.sv | 49 ++++
 rtl/mimo_split.sv | 78 +++++++
 4 files changed

// File: rtl/mimo_pkg.sv
// mimo_pkg: definitions shared by both gearbox directions (wide-to-narrow split
// and narrow-to-wide accumulate).
//   mimo_count_width : width of the valid-bit counter for a given pair of widths
//   mimo_params_ok   : legality of a (widthIn, widthOut) pair
package mimo_pkg;

  // The counter must hold 0..widthIn+widthOut inclusive.
  function automatic int mimo_count_width(input int width_in, input int width_out);
    return $clog2(width_in + width_out + 1);
  endfunction

  // The wide side must be at least as wide as the narrow side, and both non-empty.
  function automatic bit mimo_params_ok(input int width_in, input int width_out);
    return (width_in >= width_out) && (width_out >= 1);
  endfunction

endpackage

// File: rtl/mimo_split_if.sv
// mimo_split_if: handshake bundle of the width-down gearbox.
//   enq_ena / enq_v / enq_rdy       : wide input word, accepted when enq_rdy=1
//   deq_ena / deq_rdy               : narrow output pop, honoured when deq_rdy=1
//   first / first_rdy               : current narrow output word and its valid
//   count                           : number of valid bits held
// Modports: slave = gearbox side, master = producer/consumer side.
interface mimo_split_if
  import mimo_pkg::*;
#(
  parameter int WIDTH_IN  = 128,
  parameter int WIDTH_OUT = 32,
  parameter int CW        = mimo_count_width(WIDTH_IN, WIDTH_OUT)
);
  logic                 enq_ena;
  logic [WIDTH_IN-1:0]  enq_v;
  logic                 enq_rdy;
  logic                 deq_ena;
  logic                 deq_rdy;
  logic [WIDTH_OUT-1:0] first;
  logic                 first_rdy;
  logic [CW-1:0]        count;

  modport slave (
    input  enq_ena, enq_v, deq_ena,
    output enq_rdy, deq_rdy, first, first_rdy, count
  );

  modport master (
    output enq_ena, enq_v, deq_ena,
    input  enq_rdy, deq_rdy, first, first_rdy, count
  );
endinterface

// File: rtl/mimo_insert.sv
// mimo_insert: combinational next-buffer builder for MIMO gearboxes.
//   buf_i    : current buffer (valid bits in the low positions)
//   shift_i  : drop the low WIDTH_OUT bits (zero-fill at the top)
//   insert_i : write data_i into the (possibly shifted) buffer at pos_i
//   pos_i    : insert bit position, relative to the shifted buffer
//   data_i   : WIDTH_IN-bit word to insert
//   buf_o    : resulting buffer
// The insert overwrites exactly WIDTH_IN bits starting at pos_i; bits outside
// that window come from the shifted buffer unchanged.
module mimo_insert
  import mimo_pkg::*;
#(
  parameter int WIDTH_IN  = 128,
  parameter int WIDTH_OUT = 32,
  parameter int CW        = mimo_count_width(WIDTH_IN, WIDTH_OUT)
) (
  input  logic [WIDTH_IN+WIDTH_OUT-1:0] buf_i,
  input  logic                          shift_i,
  input  logic                          insert_i,
  input  logic [CW-1:0]                 pos_i,
  input  logic [WIDTH_IN-1:0]           data_i,
  output logic [WIDTH_IN+WIDTH_OUT-1:0] buf_o
);
  localparam int BW = WIDTH_IN + WIDTH_OUT;

  logic [BW-1:0] shifted;
  logic [BW-1:0] ins_data;
  logic [BW-1:0] ins_mask;

  always_comb begin
    shifted  = buf_i;
    ins_data = '0;
    ins_mask = '0;
    if (shift_i) begin
      shifted = buf_i >> WIDTH_OUT;
    end
    // Shift-based placement keeps the expression legal for any pos_i value;
    // callers only assert insert_i when pos_i + WIDTH_IN <= BW.
    if (insert_i) begin
      ins_data = {{WIDTH_OUT{1'b0}}, data_i} << pos_i;
      ins_mask = {{WIDTH_OUT{1'b0}}, {WIDTH_IN{1'b1}}} << pos_i;
    end
  end

  for (genvar gi = 0; gi < BW; gi++) begin : g_bit
    assign buf_o[gi] = ins_mask[gi] ? ins_data[gi] : shifted[gi];
  end

endmodule

// File: rtl/mimo_split.sv
// mimo_split: width-down gearbox, WIDTH_IN-bit words in, WIDTH_OUT-bit words
// out, low bits first.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset (clears buffer and count)
//   io  : mimo_split_if.slave handshake bundle
// Valid bits always sit at buffer_q[c_q-1:0]; everything above is zero, so a
// reset or drain never lets stale data resurface. Ready outputs depend only on
// registered state.
module mimo_split
  import mimo_pkg::*;
#(
  parameter int WIDTH_IN  = 128,
  parameter int WIDTH_OUT = 32
) (
  input  logic          CLK,
  input  logic          RST,
  mimo_split_if.slave   io
);
  localparam int BW = WIDTH_IN + WIDTH_OUT;
  localparam int CW = mimo_count_width(WIDTH_IN, WIDTH_OUT);
  localparam logic [CW-1:0] WI_C = CW'(WIDTH_IN);
  localparam logic [CW-1:0] WO_C = CW'(WIDTH_OUT);

  if (!mimo_params_ok(WIDTH_IN, WIDTH_OUT)) begin : g_param_check
    $error("mimo_split: WIDTH_IN >= WIDTH_OUT >= 1 required");
  end

  logic [BW-1:0] buffer_q, buffer_d;
  logic [CW-1:0] c_q, c_d;
  logic          enq_rdy, deq_rdy;
  logic          enq_fire, deq_fire;
  logic [CW-1:0] ins_pos;

  assign enq_rdy  = (c_q <= WO_C);
  assign deq_rdy  = (c_q >= WO_C);
  assign enq_fire = io.enq_ena & enq_rdy;
  assign deq_fire = io.deq_ena & deq_rdy;

  // When popping in the same cycle, the insert lands below the old fill level
  // by one output word, because the buffer shifts first.
  assign ins_pos = deq_fire ? (c_q - WO_C) : c_q;

  mimo_insert #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT),
    .CW        (CW)
  ) u_insert (
    .buf_i    (buffer_q),
    .shift_i  (deq_fire),
    .insert_i (enq_fire),
    .pos_i    (ins_pos),
    .data_i   (io.enq_v),
    .buf_o    (buffer_d)
  );

  always_comb begin
    c_d = c_q;
    if (enq_fire) c_d = c_d + WI_C;
    if (deq_fire) c_d = c_d - WO_C;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      buffer_q <= '0;
      c_q      <= '0;
    end else begin
      buffer_q <= buffer_d;
      c_q      <= c_d;
    end
  end

  assign io.enq_rdy   = enq_rdy;
  assign io.deq_rdy   = deq_rdy;
  assign io.first_rdy = deq_rdy;
  assign io.first     = buffer_q[WIDTH_OUT-1:0];
  assign io.count     = c_q;

endmodule
